// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-128 round sequencer: the FSM state encoding,
// the round count and the block width.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NR = 10;   // AES-128 cipher rounds
  localparam int AES_W  = 128;  // block and key width

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_FIRST = 3'd2,
    S_MID   = 3'd3,
    S_LAST  = 3'd4,
    S_CAPT  = 3'd5,
    S_DONE  = 3'd6
  } aes_state_e;

endpackage

// File: rtl/aes_round_cnt.sv
// -----------------------------------------------------------------------------
// aes_round_cnt
// 4-bit loadable up-counter holding the current AES round index.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset (count -> 0)
//   clr_i     synchronous clear to 0
//   ld_i      load ld_val_i (lower priority than clr_i)
//   ld_val_i  value to load
//   inc_i     increment by one (saturates at 15, never wraps)
//   cnt_o     registered count
//   term_o    count equals TERM (last MID round reached)
// -----------------------------------------------------------------------------
module aes_round_cnt #(
  parameter logic [3:0] TERM = 4'd9
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       ld_i,
  input  logic [3:0] ld_val_i,
  input  logic       inc_i,
  output logic [3:0] cnt_o,
  output logic       term_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: clear, load, saturating increment or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (inc_i && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
// Sequencer in front of the AES-128 round datapath. Accepts one plaintext/key
// pair per iStart/oReady handshake, holds them stable, walks the datapath
// through INIT, FIRST, NUM_RND-2 x MID and LAST rounds with one-hot registered
// flags, captures the datapath state register and presents the ciphertext on
// an oCpValid/iCpReady port until the sink takes it.
// Ports:
//   iClk, iRst                 clock, synchronous active-high reset
//   iAbort                     (only with AES_CTRL_ABORT_EN) drop in-flight block
//   iStart / oReady            input handshake; oReady high only in IDLE
//   iPlainText, iAesKey        block inputs, sampled on accept
//   oPlainText, oAesKey        held block to the round datapath
//   o*RoundFlag                one-hot round flags (INIT, FIRST, MID, LAST)
//   oRoundCnt                  current round index
//   iCpText                    datapath state register output
//   oCpValid / iCpReady        output handshake
//   oCpText                    registered ciphertext
// Configuration macro:
//   AES_CTRL_ABORT_EN  adds iAbort; any non-IDLE state returns to IDLE.
// -----------------------------------------------------------------------------
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int DATA_W  = AES_W,
  parameter int NUM_RND = AES_NR
) (
  input  logic              iClk,
  input  logic              iRst,
`ifdef AES_CTRL_ABORT_EN
  input  logic              iAbort,
`endif
  input  logic              iStart,
  output logic              oReady,
  input  logic [DATA_W-1:0] iPlainText,
  input  logic [DATA_W-1:0] iAesKey,
  output logic [DATA_W-1:0] oPlainText,
  output logic [DATA_W-1:0] oAesKey,
  output logic              oInitRoundFlag,
  output logic              oFstRoundFlag,
  output logic              oMidRoundFlag,
  output logic              oLstRoundFlag,
  output logic [3:0]        oRoundCnt,
  input  logic [DATA_W-1:0] iCpText,
  output logic              oCpValid,
  input  logic              iCpReady,
  output logic [DATA_W-1:0] oCpText
);

  localparam logic [3:0] MID_TERM = 4'(NUM_RND - 1);

  aes_state_e        state_q, state_d, nxt_s;
  logic [DATA_W-1:0] pt_q, key_q, cp_q;
  logic              ready_q, valid_q;
  logic              init_q, fst_q, mid_q, lst_q;
  logic              accept_s, abort_s;
  logic              cnt_clr_s, cnt_ld_s, cnt_inc_s, cnt_term_s;
  logic [3:0]        cnt_ld_val_s;

  assign accept_s = iStart && (state_q == S_IDLE);

`ifdef AES_CTRL_ABORT_EN
  assign abort_s = iAbort && (state_q != S_IDLE);
`else
  assign abort_s = 1'b0;
`endif

  // Next-state logic; abort overrides the normal sequence.
  always_comb begin
    nxt_s = state_q;
    case (state_q)
      S_IDLE:  if (accept_s) nxt_s = S_INIT; else nxt_s = S_IDLE;
      S_INIT:  nxt_s = S_FIRST;
      S_FIRST: nxt_s = S_MID;
      S_MID:   if (cnt_term_s) nxt_s = S_LAST; else nxt_s = S_MID;
      S_LAST:  nxt_s = S_CAPT;
      S_CAPT:  nxt_s = S_DONE;
      S_DONE:  if (iCpReady) nxt_s = S_IDLE; else nxt_s = S_DONE;
      default: nxt_s = S_IDLE;
    endcase
    state_d = abort_s ? S_IDLE : nxt_s;
  end

  // Round counter control, keyed on the state being entered so the count is
  // aligned with the flags: 0 in INIT, 1 in FIRST, 2.. in MID, NUM_RND in LAST.
  always_comb begin
    cnt_clr_s    = 1'b0;
    cnt_ld_s     = 1'b0;
    cnt_ld_val_s = 4'd0;
    cnt_inc_s    = 1'b0;
    case (state_d)
      S_IDLE, S_INIT: cnt_clr_s = 1'b1;
      S_FIRST: begin
        cnt_ld_s     = 1'b1;
        cnt_ld_val_s = 4'd1;
      end
      S_MID: begin
        if (state_q == S_FIRST) begin
          cnt_ld_s     = 1'b1;
          cnt_ld_val_s = 4'd2;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      S_LAST:  cnt_inc_s = 1'b1;
      default: cnt_clr_s = 1'b0;  // CAPT/DONE hold the final index
    endcase
  end

  aes_round_cnt #(.TERM(MID_TERM)) u_round_cnt (
    .clk_i    (iClk),
    .rst_i    (iRst),
    .clr_i    (cnt_clr_s),
    .ld_i     (cnt_ld_s),
    .ld_val_i (cnt_ld_val_s),
    .inc_i    (cnt_inc_s),
    .cnt_o    (oRoundCnt),
    .term_o   (cnt_term_s)
  );

  // State register and registered decodes of the next state for all flags.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      init_q  <= 1'b0;
      fst_q   <= 1'b0;
      mid_q   <= 1'b0;
      lst_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
      valid_q <= (state_d == S_DONE);
      init_q  <= (state_d == S_INIT);
      fst_q   <= (state_d == S_FIRST);
      mid_q   <= (state_d == S_MID);
      lst_q   <= (state_d == S_LAST);
    end
  end

  // Block and ciphertext holding registers; an abort in CAPT keeps the old text.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pt_q  <= '0;
      key_q <= '0;
      cp_q  <= '0;
    end else begin
      if (accept_s) begin
        pt_q  <= iPlainText;
        key_q <= iAesKey;
      end
      if ((state_q == S_CAPT) && !abort_s) begin
        cp_q <= iCpText;
      end
    end
  end

  assign oReady         = ready_q;
  assign oCpValid       = valid_q;
  assign oInitRoundFlag = init_q;
  assign oFstRoundFlag  = fst_q;
  assign oMidRoundFlag  = mid_q;
  assign oLstRoundFlag  = lst_q;
  assign oPlainText     = pt_q;
  assign oAesKey        = key_q;
  assign oCpText        = cp_q;

endmodule
